// File: rtl/upbus_arb2.sv
// upbus_arb2: two-master round-robin arbiter for the 32-bit internal up_* bus.
// Master 0 is the CPLD host bridge (active-low level request) and master 1 is the
// internal init/config sequencer (active-high level request). Every slave-side
// strobe is registered. A no-response watchdog completes hung accesses with a
// 32'hCAFECAFE read pattern and logs the address of the first one.
//
// Handshake: a master raises its request level together with a stable command and
// holds it until its 1-cycle mX_rdy pulse, then releases it. A request that stays
// asserted after its rdy is not served again until it has been released for at
// least one cycle. Dropping the request before rdy aborts the access with no rdy.
module upbus_arb2 #(
    parameter int                TOUT_W   = 12,
    parameter logic [TOUT_W-1:0] TOUT_CYC = 12'hFFF
) (
    input  logic        sclk,
    input  logic        rst_,
    // master 0: CPLD host bridge
    input  logic        m0_cs_,
    input  logic        m0_rnw,
    input  logic [23:0] m0_addr,
    input  logic [31:0] m0_wrd,
    output logic [31:0] m0_rdd,
    output logic        m0_rdy,
    // master 1: internal sequencer
    input  logic        m1_req,
    input  logic        m1_rnw,
    input  logic [23:0] m1_addr,
    input  logic [31:0] m1_wrd,
    output logic [31:0] m1_rdd,
    output logic        m1_rdy,
    // slave side
    output logic        up_cs_,
    output logic        up_rd,
    output logic        up_wr,
    output logic        up_rnw,
    output logic [23:0] up_addr,
    output logic [31:0] up_wrd,
    input  logic [31:0] up_rdd,
    input  logic        up_rdy,
    // status
    output logic [1:0]  gnt,
    output logic        tout_err,
    output logic [23:0] tout_addr,
    input  logic        tout_clr,
    // arbiter state for debug/checkers: 0 IDLE, 1 GNT0, 2 GNT1, 3 DONE
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [TOUT_W-1:0] WD_LAST = TOUT_CYC - {{(TOUT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]       TOUT_PATTERN = 32'hCAFECAFE;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_up_cs_;
    logic               r_up_rd;
    logic               r_up_wr;
    logic [23:0]        r_up_addr;
    logic [31:0]        r_up_wrd;
    logic [31:0]        r_m0_rdd;
    logic [31:0]        r_m1_rdd;
    logic               r_m0_rdy;
    logic               r_m1_rdy;
    logic [1:0]         r_gnt;
    logic               r_last;      // 1 = master 1 was granted last
    logic               r_served0;
    logic               r_served1;
    logic [TOUT_W-1:0]  r_wd;
    logic               r_tout_err;
    logic [23:0]        r_tout_addr;

    logic               w_req0;
    logic               w_req1;
    logic               w_own_req;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_cmpl;
    logic               w_tout;
    logic               w_abort;
    logic               w_end;
    logic               w_own1;

    // A request counts only until it has been served once in its current assertion
    assign w_req0 = !m0_cs_ && !r_served0;
    assign w_req1 = m1_req && !r_served1;
    assign w_own1 = (r_state == S_GNT1);
    assign w_end  = w_abort || w_cmpl || w_tout;

    // State register
    always_ff @(posedge sclk or negedge rst_) begin
        if (!rst_) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant0)      w_next_state = S_GNT0;
                else if (w_grant1) w_next_state = S_GNT1;
            end
            S_GNT0, S_GNT1: begin
                if (w_end) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Event decode: grant choice in IDLE, end-of-access reason in GNT.
    // Abort beats slave completion, and completion beats watchdog expiry.
    always_comb begin
        w_grant0  = 1'b0;
        w_grant1  = 1'b0;
        w_cmpl    = 1'b0;
        w_tout    = 1'b0;
        w_abort   = 1'b0;
        w_own_req = w_own1 ? m1_req : !m0_cs_;
        case (r_state)
            S_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_grant0 = r_last;
                    w_grant1 = !r_last;
                end else begin
                    w_grant0 = w_req0;
                    w_grant1 = w_req1;
                end
            end
            S_GNT0, S_GNT1: begin
                if (!w_own_req)           w_abort = 1'b1;
                else if (up_rdy)          w_cmpl  = 1'b1;
                else if (r_wd == WD_LAST) w_tout  = 1'b1;
            end
            default: ;
        endcase
    end

    // Slave strobes, grant, master return path and watchdog
    always_ff @(posedge sclk or negedge rst_) begin
        if (!rst_) begin
            r_up_cs_  <= 1'b1;
            r_up_rd   <= 1'b0;
            r_up_wr   <= 1'b0;
            r_up_addr <= 24'h0;
            r_up_wrd  <= 32'h0;
            r_m0_rdd  <= 32'h0;
            r_m1_rdd  <= 32'h0;
            r_m0_rdy  <= 1'b0;
            r_m1_rdy  <= 1'b0;
            r_gnt     <= 2'b00;
            r_last    <= 1'b1;
            r_wd      <= '0;
        end else begin
            r_m0_rdy <= 1'b0;
            r_m1_rdy <= 1'b0;
            if (w_grant0 || w_grant1) begin
                r_up_cs_  <= 1'b0;
                r_up_addr <= w_grant1 ? m1_addr : m0_addr;
                r_up_wrd  <= w_grant1 ? m1_wrd  : m0_wrd;
                r_up_rd   <= w_grant1 ? m1_rnw  : m0_rnw;
                r_up_wr   <= w_grant1 ? !m1_rnw : !m0_rnw;
                r_gnt     <= {w_grant1, w_grant0};
                r_last    <= w_grant1;
                r_wd      <= '0;
            end else if (w_end) begin
                r_up_cs_ <= 1'b1;
                r_up_rd  <= 1'b0;
                r_up_wr  <= 1'b0;
                r_gnt    <= 2'b00;
                if (w_cmpl || w_tout) begin
                    if (w_own1) r_m1_rdy <= 1'b1;
                    else        r_m0_rdy <= 1'b1;
                end
                // writes leave the previous read data in place
                if (w_tout) begin
                    if (w_own1) r_m1_rdd <= TOUT_PATTERN;
                    else        r_m0_rdd <= TOUT_PATTERN;
                end else if (w_cmpl && r_up_rd) begin
                    if (w_own1) r_m1_rdd <= up_rdd;
                    else        r_m0_rdd <= up_rdd;
                end
            end else if (r_state == S_GNT0 || r_state == S_GNT1) begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    // Served flags: released request always clears, rdy pulse marks it served
    always_ff @(posedge sclk or negedge rst_) begin
        if (!rst_) begin
            r_served0 <= 1'b0;
            r_served1 <= 1'b0;
        end else begin
            if (m0_cs_)        r_served0 <= 1'b0;
            else if (r_m0_rdy) r_served0 <= 1'b1;
            if (!m1_req)       r_served1 <= 1'b0;
            else if (r_m1_rdy) r_served1 <= 1'b1;
        end
    end

    // Sticky timeout log; a timeout outranks a simultaneous clear and reloads the address
    always_ff @(posedge sclk or negedge rst_) begin
        if (!rst_) begin
            r_tout_err  <= 1'b0;
            r_tout_addr <= 24'h0;
        end else if (w_tout) begin
            r_tout_err <= 1'b1;
            if (!r_tout_err || tout_clr) r_tout_addr <= r_up_addr;
        end else if (tout_clr) begin
            r_tout_err  <= 1'b0;
            r_tout_addr <= 24'h0;
        end
    end

    assign up_cs_    = r_up_cs_;
    assign up_rd     = r_up_rd;
    assign up_wr     = r_up_wr;
    assign up_rnw    = r_up_rd;
    assign up_addr   = r_up_addr;
    assign up_wrd    = r_up_wrd;
    assign m0_rdd    = r_m0_rdd;
    assign m1_rdd    = r_m1_rdd;
    assign m0_rdy    = r_m0_rdy;
    assign m1_rdy    = r_m1_rdy;
    assign gnt       = r_gnt;
    assign tout_err  = r_tout_err;
    assign tout_addr = r_tout_addr;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_upbus_arb2.sv
// tb_upbus_arb2: directed bench for upbus_arb2 with a small slave model and a
// completion scoreboard of {master, rdd} entries in expected completion order.
module tb_upbus_arb2;

    localparam int          TOUT_W   = 12;
    localparam logic [11:0] TOUT_CYC = 12'd20;

    logic        sclk;
    logic        rst_;
    logic        m0_cs_, m0_rnw;
    logic [23:0] m0_addr;
    logic [31:0] m0_wrd, m0_rdd;
    logic        m0_rdy;
    logic        m1_req, m1_rnw;
    logic [23:0] m1_addr;
    logic [31:0] m1_wrd, m1_rdd;
    logic        m1_rdy;
    logic        up_cs_, up_rd, up_wr, up_rnw;
    logic [23:0] up_addr;
    logic [31:0] up_wrd, up_rdd;
    logic        up_rdy;
    logic [1:0]  gnt;
    logic        tout_err;
    logic [23:0] tout_addr;
    logic        tout_clr;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [32:0] exp_q[$];
    logic [31:0] last0, last1;

    int          slv_lat  = 0;
    bit          slv_rand = 0;
    bit          slv_fix  = 0;
    logic [31:0] slv_data = 32'h0;

    upbus_arb2 #(.TOUT_W(TOUT_W), .TOUT_CYC(TOUT_CYC)) dut (
        .sclk(sclk), .rst_(rst_),
        .m0_cs_(m0_cs_), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wrd(m0_wrd),
        .m0_rdd(m0_rdd), .m0_rdy(m0_rdy),
        .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wrd(m1_wrd),
        .m1_rdd(m1_rdd), .m1_rdy(m1_rdy),
        .up_cs_(up_cs_), .up_rd(up_rd), .up_wr(up_wr), .up_rnw(up_rnw),
        .up_addr(up_addr), .up_wrd(up_wrd), .up_rdd(up_rdd), .up_rdy(up_rdy),
        .gnt(gnt), .tout_err(tout_err), .tout_addr(tout_addr), .tout_clr(tout_clr),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // waits (bounded) for the rdy pulse of master mid, counting cs-low and rd cycles
    task automatic wait_rdy(input bit mid, input int budget, output int ncs, output int nrd);
        bit seen = 1'b0;
        ncs = 0;
        nrd = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (up_cs_ == 1'b0) ncs++;
            if (up_rd == 1'b1) nrd++;
            if ((mid ? m1_rdy : m0_rdy) == 1'b1) seen = 1'b1;
            else cyc(1);
        end
        check(mid ? "m1_rdy_seen" : "m0_rdy_seen", {63'h0, seen}, 64'h1);
    endtask

    task automatic push(input bit mid, input logic [31:0] rdd);
        exp_q.push_back({mid, rdd});
        if (mid) last1 = rdd;
        else     last0 = rdd;
    endtask

    task automatic sb_pop(input bit mid, input logic [31:0] rdd);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected_rdy: observed m%0d rdd %0h expected no rdy", mid, rdd);
            end
        end else begin
            e = exp_q.pop_front();
            check("sb_completion", {31'h0, mid, rdd}, {31'h0, e});
        end
    endtask

    // scoreboard consumer
    always @(negedge sclk) begin
        if (rst_ === 1'b1) begin
            if (m0_rdy === 1'b1) sb_pop(1'b0, m0_rdd);
            if (m1_rdy === 1'b1) sb_pop(1'b1, m1_rdd);
        end
    end

    // slave model: rdy in the lat-th cs-low cycle (lat 0 = never answers)
    initial begin
        int cnt = 0;
        int lat = 0;
        up_rdy = 1'b0;
        up_rdd = 32'h0;
        forever begin
            @(posedge sclk);
            #1;
            if (up_cs_ == 1'b0) begin
                if (cnt == 0) lat = slv_rand ? int'($urandom_range(1, 4)) : slv_lat;
                cnt++;
            end else begin
                cnt = 0;
            end
            up_rdy = (up_cs_ == 1'b0) && (lat != 0) && (cnt == lat);
            up_rdd = slv_fix ? slv_data : {8'h5A, up_addr};
        end
    end

    // directed stimulus
    initial begin
        int ncs, nrd, c0, c1;
        rst_ = 1'b0;
        m0_cs_ = 1'b1; m0_rnw = 1'b1; m0_addr = 24'h0; m0_wrd = 32'h0;
        m1_req = 1'b0; m1_rnw = 1'b1; m1_addr = 24'h0; m1_wrd = 32'h0;
        tout_clr = 1'b0;
        last0 = 32'h0; last1 = 32'h0;
        cyc(3);
        check("rst_up_cs_", {63'h0, up_cs_}, 64'h1);
        check("rst_strobes", {61'h0, up_rd, up_wr, up_rnw}, 64'h0);
        check("rst_gnt", {62'h0, gnt}, 64'h0);
        check("rst_state", {62'h0, dbg_state}, 64'h0);
        check("rst_tout", {39'h0, tout_err, tout_addr}, 64'h0);
        check("rst_rdd", {m0_rdd, m1_rdd}, 64'h0);
        rst_ = 1'b1;
        cyc(2);

        // m0 read, slave answers in the 3rd cs-low cycle with fixed data
        slv_fix = 1'b1; slv_data = 32'h12345678; slv_lat = 3;
        m0_cs_ = 1'b0; m0_rnw = 1'b1; m0_addr = 24'h000123;
        push(1'b0, 32'h12345678);
        cyc(1);
        check("t1_gnt", {62'h0, gnt}, 64'h1);
        check("t1_strobes", {61'h0, up_rd, up_wr, up_rnw}, 64'h5);
        check("t1_addr", {40'h0, up_addr}, 64'h000123);
        wait_rdy(1'b0, 40, ncs, nrd);
        check("t1_rd_cycles", nrd, 3);
        check("t1_cs_after", {62'h0, up_cs_, m0_rdy}, 64'h3);
        m0_cs_ = 1'b1;
        cyc(1);
        check("t1_rdy_pulse", {62'h0, up_cs_, m0_rdy}, 64'h2);
        slv_fix = 1'b0;
        cyc(2);

        // request held after rdy is not served a second time
        slv_lat = 1;
        m0_cs_ = 1'b0; m0_addr = 24'h000600;
        push(1'b0, {8'h5A, 24'h000600});
        wait_rdy(1'b0, 40, ncs, nrd);
        cyc(5);
        check("hold_no_regrant", {61'h0, up_cs_, gnt}, 64'h4);
        check("hold_idle", {62'h0, dbg_state}, 64'h0);
        m0_cs_ = 1'b1;
        cyc(2);

        // fresh reset, then both masters request together and keep re-requesting
        rst_ = 1'b0; last0 = 32'h0; last1 = 32'h0;
        cyc(2);
        rst_ = 1'b1;
        cyc(2);
        slv_rand = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(1'b0, {8'h5A, 24'h000100 + 24'(k)});
            push(1'b1, {8'h5A, 24'h000200 + 24'(k)});
        end
        c0 = 0; c1 = 0;
        m0_cs_ = 1'b0; m0_rnw = 1'b1; m0_addr = 24'h000100;
        m1_req = 1'b1; m1_rnw = 1'b1; m1_addr = 24'h000200;
        cyc(1);
        check("rr_first_m0", {62'h0, gnt}, 64'h1);
        for (int t = 0; t < 400 && (c0 < 3 || c1 < 3); t++) begin
            cyc(1);
            if (m0_cs_ == 1'b1 && c0 < 3) begin
                m0_cs_ = 1'b0; m0_addr = 24'h000100 + 24'(c0);
            end
            if (m1_req == 1'b0 && c1 < 3) begin
                m1_req = 1'b1; m1_addr = 24'h000200 + 24'(c1);
            end
            if (m0_rdy == 1'b1) begin c0++; m0_cs_ = 1'b1; end
            if (m1_rdy == 1'b1) begin c1++; m1_req = 1'b0; end
        end
        check("rr_counts", {c0, c1}, {32'd3, 32'd3});
        slv_rand = 1'b0;
        cyc(2);

        // m1 write, slave silent: forced completion after TOUT_CYC GNT cycles
        slv_lat = 0;
        m1_req = 1'b1; m1_rnw = 1'b0; m1_addr = 24'h00ABCD; m1_wrd = 32'hDEADBEEF;
        push(1'b1, 32'hCAFECAFE);
        cyc(1);
        check("to1_gnt", {62'h0, gnt}, 64'h2);
        check("to1_wr", {31'h0, up_wr, up_wrd}, {31'h0, 1'b1, 32'hDEADBEEF});
        wait_rdy(1'b1, 60, ncs, nrd);
        check("to1_cycles", ncs, int'(TOUT_CYC));
        check("to1_log", {39'h0, tout_err, tout_addr}, {39'h0, 1'b1, 24'h00ABCD});
        m1_req = 1'b1;
        cyc(1);
        m1_req = 1'b0;
        cyc(2);

        // second timeout keeps the first address
        m0_cs_ = 1'b0; m0_rnw = 1'b1; m0_addr = 24'h000777;
        push(1'b0, 32'hCAFECAFE);
        wait_rdy(1'b0, 60, ncs, nrd);
        check("to2_keep", {39'h0, tout_err, tout_addr}, {39'h0, 1'b1, 24'h00ABCD});
        m0_cs_ = 1'b1;
        cyc(2);

        // clear coinciding with a timeout: flag stays, address reloaded
        m1_req = 1'b1; m1_rnw = 1'b1; m1_addr = 24'h000BBB;
        push(1'b1, 32'hCAFECAFE);
        cyc(1);
        cyc(int'(TOUT_CYC) - 1);
        tout_clr = 1'b1;
        cyc(1);
        tout_clr = 1'b0;
        check("to3_rdy", {63'h0, m1_rdy}, 64'h1);
        check("to3_reload", {39'h0, tout_err, tout_addr}, {39'h0, 1'b1, 24'h000BBB});
        m1_req = 1'b0;
        cyc(2);
        tout_clr = 1'b1;
        cyc(1);
        tout_clr = 1'b0;
        check("clr", {39'h0, tout_err, tout_addr}, 64'h0);
        cyc(1);

        // slave answers exactly on the watchdog expiry cycle: real data, no error
        slv_lat = int'(TOUT_CYC);
        m0_cs_ = 1'b0; m0_rnw = 1'b1; m0_addr = 24'h000456;
        push(1'b0, {8'h5A, 24'h000456});
        wait_rdy(1'b0, 60, ncs, nrd);
        check("race_cycles", ncs, int'(TOUT_CYC));
        check("race_no_err", {63'h0, tout_err}, 64'h0);
        m0_cs_ = 1'b1;
        cyc(2);

        // m0 aborts in the cycle the slave answers; waiting m1 follows after DONE
        slv_lat = 3;
        m0_cs_ = 1'b0; m0_rnw = 1'b1; m0_addr = 24'h000300;
        cyc(1);
        m1_req = 1'b1; m1_rnw = 1'b1; m1_addr = 24'h000400;
        push(1'b1, {8'h5A, 24'h000400});
        cyc(2);
        m0_cs_ = 1'b1;
        cyc(1);
        check("abort_cs_high", {61'h0, up_cs_, gnt}, 64'h4);
        check("abort_no_rdy", {63'h0, m0_rdy}, 64'h0);
        cyc(2);
        check("abort_m1_gnt", {62'h0, gnt}, 64'h2);
        wait_rdy(1'b1, 40, ncs, nrd);
        check("abort_m1_cycles", ncs, 3);
        m1_req = 1'b0;
        cyc(2);

        // m1 write completes normally and returns the previous rdd
        slv_lat = 2;
        m1_req = 1'b1; m1_rnw = 1'b0; m1_addr = 24'h000500; m1_wrd = 32'h01020304;
        push(1'b1, last1);
        cyc(1);
        check("wr_strobes", {61'h0, up_rd, up_wr, up_rnw}, 64'h2);
        check("wr_data", {8'h0, up_addr, up_wrd}, {8'h0, 24'h000500, 32'h01020304});
        wait_rdy(1'b1, 40, ncs, nrd);
        m1_req = 1'b0;
        cyc(2);

        // asynchronous reset in the middle of an access
        slv_lat = 0;
        m0_cs_ = 1'b0; m0_rnw = 1'b1; m0_addr = 24'h000700;
        cyc(2);
        check("arst_pre", {63'h0, up_cs_}, 64'h0);
        #2;
        rst_ = 1'b0;
        #1;
        check("arst_bus", {60'h0, up_cs_, up_rd, gnt}, 64'h8);
        check("arst_state", {62'h0, dbg_state}, 64'h0);
        check("arst_rdd", {m0_rdd, m1_rdd}, 64'h0);
        cyc(1);
        m0_cs_ = 1'b1;
        rst_ = 1'b1;
        cyc(4);

        check("sb_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
